// File: rtl/tmp_pkg.sv
// tmp_pkg: shared state encoding and default sizing for the measurement scheduler
package tmp_pkg;
   localparam int PER_W_DEF   = 12;
   localparam int RST_CYC_DEF = 4;
   typedef enum logic [2:0] {IDLE, CORE_RST, SETTLE, MEASURE, DONE} state_t;
endpackage

// File: rtl/tmp_meas_sched_if.sv
// tmp_meas_sched_if: valid/ready result stream from the scheduler to its consumer
interface tmp_meas_sched_if import tmp_pkg::*; #(
   parameter int PER_W = PER_W_DEF
);
   logic             res_valid;
   logic             res_ready;
   logic [PER_W-1:0] res_data;
   modport master (output res_valid, output res_data, input res_ready);
   modport slave (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/tmp_period_ctr.sv
// tmp_period_ctr: core_valid rising-edge detector and saturating period counter
module tmp_period_ctr import tmp_pkg::*; #(
   parameter int PER_W = PER_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             core_valid,
   output logic             edge_hit,
   output logic [PER_W-1:0] per_cnt,
   output logic             sat
);
   logic cv_q;
   assign edge_hit = core_valid & ~cv_q;
   assign sat = &per_cnt;
   // edge register always follows core_valid; counter restarts at 1 on each edge and sticks at full scale
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cv_q    <= 1'b0;
         per_cnt <= '0;
      end else begin
         cv_q    <= core_valid;
         per_cnt <= clr ? '0 : edge_hit ? PER_W'(1) : sat ? per_cnt : per_cnt + 1'b1;
      end
endmodule

// File: rtl/tmp_meas_sched.sv
// tmp_meas_sched: resets the sensor core, averages 2^avg_sel edge periods and hands out the result
module tmp_meas_sched import tmp_pkg::*; #(
   parameter int PER_W   = PER_W_DEF,
   parameter int RST_CYC = RST_CYC_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cont,
   input  logic [1:0]       avg_sel,
   input  logic             core_valid,
   output logic             core_rst,
   output logic             busy,
   output logic             timeout_err,
   tmp_meas_sched_if.master res
);
   localparam int RC_W = RST_CYC > 1 ? $clog2(RST_CYC) : 1;
   state_t           state, state_n;
   logic [RC_W-1:0]  rc;
   logic [1:0]       avg;
   logic [3:0]       cnt;
   logic [PER_W+2:0] accum, accum_n;
   logic [PER_W-1:0] per_cnt, res_q;
   logic             edge_hit, sat, meas, last, go;
   assign meas = state == SETTLE || state == MEASURE;
   assign go = state == IDLE && (start || cont);
   assign last = (cnt + 4'd1) == (4'd1 << avg);
   assign accum_n = accum + (PER_W+3)'(per_cnt);
   assign core_rst = state == IDLE || state == CORE_RST;
   assign busy = state != IDLE;
   assign res.res_valid = state == DONE;
   assign res.res_data = res_q;
   tmp_period_ctr #(.PER_W(PER_W)) u_ctr (
      .clk        (clk),
      .reset      (reset),
      .clr        (!meas),
      .core_valid (core_valid),
      .edge_hit   (edge_hit),
      .per_cnt    (per_cnt),
      .sat        (sat)
   );
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   // next state: saturation in SETTLE/MEASURE aborts, the first edge after settling is discarded
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = go ? CORE_RST : IDLE;
         CORE_RST: state_n = rc == RC_W'(RST_CYC - 1) ? SETTLE : CORE_RST;
         SETTLE:   state_n = sat ? IDLE : edge_hit ? MEASURE : SETTLE;
         MEASURE:  state_n = sat ? IDLE : (edge_hit && last) ? DONE : MEASURE;
         DONE:     state_n = res.res_ready ? (cont ? SETTLE : IDLE) : DONE;
         default:  state_n = IDLE;
      endcase
   end
   // datapath: reset-cycle count, accumulation per edge, result capture and sticky timeout
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rc          <= '0;
         avg         <= '0;
         cnt         <= '0;
         accum       <= '0;
         res_q       <= '0;
         timeout_err <= 1'b0;
      end else begin
         rc <= state == CORE_RST ? rc + 1'b1 : '0;
         if (go) begin
            avg         <= avg_sel;
            timeout_err <= 1'b0;
         end
         if (meas && sat) timeout_err <= 1'b1;
         if (state == MEASURE && edge_hit && !sat) begin
            accum <= accum_n;
            cnt   <= cnt + 4'd1;
            if (last) res_q <= PER_W'(accum_n >> avg);
         end else if (state != MEASURE) begin
            accum <= '0;
            cnt   <= '0;
         end
      end
endmodule

// File: tb/tb_tmp_meas_sched.sv
// tb_tmp_meas_sched: directed scoreboard bench for the measurement scheduler
module tb_tmp_meas_sched;
   logic       clk, reset, start, cont, core_valid;
   logic [1:0] avg_sel;
   logic       core_rst, busy, timeout_err;
   int         total = 0, bad = 0, n_push = 0, n_res = 0;
   int         exp_q[$];
   tmp_meas_sched_if #(.PER_W(12)) res ();
   tmp_meas_sched dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cont        (cont),
      .avg_sel     (avg_sel),
      .core_valid  (core_valid),
      .core_rst    (core_rst),
      .busy        (busy),
      .timeout_err (timeout_err),
      .res         (res)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic pulse;
      core_valid = 1'b1;
      tick;
      core_valid = 1'b0;
   endtask
   task automatic start_meas(input logic [1:0] a, output int n);
      start = 1'b1;
      avg_sel = a;
      tick;
      start = 1'b0;
      n = 0;
      while (core_rst === 1'b1 && n < 20) begin
         n++;
         tick;
      end
   endtask
   task automatic edges(input int a, input int n, input int base, input int step, input bit push, input int poke);
      int s = 0;
      for (int i = 0; i < n; i++) s += base + i * step;
      if (push) begin
         exp_q.push_back(s >> a);
         n_push++;
      end
      pulse;
      for (int i = 0; i < n; i++) begin
         if (i == poke) begin
            start = 1'b1;
            tick;
            start = 1'b0;
            chk("poke_busy", busy, 1);
            chk("poke_core_rst", core_rst, 0);
            repeat (base + i * step - 2) tick;
         end else repeat (base + i * step - 1) tick;
         pulse;
      end
   endtask
   task automatic get_result(input string tag, input int hold, input bit noise, input logic eb);
      int n = 0, e = -1, bh = 0;
      while (res.res_valid !== 1'b1 && n < 50) begin
         tick;
         n++;
      end
      chk({tag, "_valid"}, res.res_valid, 1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, "_data"}, res.res_data, e);
      for (int k = 0; k < hold; k++) begin
         core_valid = noise && (k % 5 == 0);
         tick;
         if (!(res.res_valid === 1'b1 && res.res_data === 12'(e))) bh++;
      end
      core_valid = 1'b0;
      if (hold > 0) chk({tag, "_hold"}, bh, 0);
      res.res_ready = 1'b1;
      tick;
      res.res_ready = 1'b0;
      n_res++;
      chk({tag, "_drop"}, res.res_valid, 0);
      chk({tag, "_busy"}, busy, eb);
   endtask
   initial begin
      int n, v;
      reset = 1'b1;
      start = 1'b0;
      cont = 1'b0;
      avg_sel = 2'd0;
      core_valid = 1'b0;
      res.res_ready = 1'b0;
      repeat (3) tick;
      reset = 1'b0;
      tick;
      chk("rst_core_rst", core_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", res.res_valid, 0);
      chk("rst_data", res.res_data, 0);
      chk("rst_timeout", timeout_err, 0);
      // single sample, period 100, consumer waits a few cycles
      start_meas(2'd0, n);
      chk("core_rst_cycles", n, 4);
      chk("settle_busy", busy, 1);
      edges(0, 1, 100, 0, 1'b1, -1);
      get_result("single", 5, 1'b0, 1'b0);
      // four samples 98..104, ready already high when the result appears
      res.res_ready = 1'b1;
      start_meas(2'd2, n);
      edges(2, 4, 98, 2, 1'b1, -1);
      chk("early_ready_valid", res.res_valid, 1);
      get_result("avg4", 0, 1'b0, 1'b0);
      // no edges after the core reset: timeout
      start_meas(2'd0, n);
      n = 0;
      while (timeout_err !== 1'b1 && n < 5000) begin
         tick;
         n++;
      end
      chk("timeout_cycles", n, 4096);
      chk("timeout_busy", busy, 0);
      chk("timeout_core_rst", core_rst, 1);
      chk("timeout_valid", res.res_valid, 0);
      repeat (5) tick;
      chk("timeout_sticky", timeout_err, 1);
      start_meas(2'd0, n);
      chk("timeout_cleared", timeout_err, 0);
      edges(0, 1, 50, 0, 1'b1, -1);
      get_result("after_to", 0, 1'b0, 1'b0);
      // continuous mode with a slow consumer and edges arriving while the result waits
      cont = 1'b1;
      start_meas(2'd0, n);
      edges(0, 1, 60, 0, 1'b1, -1);
      get_result("cont1", 20, 1'b1, 1'b1);
      chk("cont_rearm_core_rst", core_rst, 0);
      edges(0, 1, 70, 0, 1'b1, -1);
      get_result("cont2", 0, 1'b0, 1'b1);
      cont = 1'b0;
      edges(0, 1, 80, 0, 1'b1, -1);
      get_result("cont3", 0, 1'b0, 1'b0);
      // reset after two of four samples
      start_meas(2'd2, n);
      edges(2, 2, 100, 0, 1'b0, -1);
      repeat (10) tick;
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_core_rst", core_rst, 1);
      chk("mid_rst_valid", res.res_valid, 0);
      chk("mid_rst_data", res.res_data, 0);
      tick;
      reset = 1'b0;
      v = 0;
      for (int k = 0; k < 20; k++) begin
         tick;
         if (res.res_valid !== 1'b0 || busy !== 1'b0) v++;
      end
      chk("mid_rst_quiet", v, 0);
      start_meas(2'd2, n);
      edges(2, 4, 90, 2, 1'b1, -1);
      get_result("restart", 0, 1'b0, 1'b0);
      // start pulsed during MEASURE is ignored
      start_meas(2'd2, n);
      edges(2, 4, 100, 0, 1'b1, 2);
      get_result("poke", 0, 1'b0, 1'b0);
      repeat (10) tick;
      chk("poke_no_restart", busy, 0);
      chk("result_count", n_res, n_push);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tmp_meas_sched.md
TMP_MEAS_SCHED -- requirements
Module: tmp_meas_sched

Interface
REQ-001 SHALL have parameter PER_W, default 12, width of period counter and result.
REQ-002 SHALL have parameter RST_CYC, default 4, number of cycles core_rst is held at each conversion start.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-shot request; sampled only in IDLE.
REQ-006 SHALL have port cont, input, 1, continuous mode; re-arms after each delivered result.
REQ-007 SHALL have port avg_sel, input, 2, averaging count of 2^avg_sel samples (1/2/4/8); latched at start.
REQ-008 SHALL have port core_valid, input, 1, sensor core output-phase flag (synchronous to clk).
REQ-009 SHALL have port res_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port core_rst, output, 1, drives sensor core rst (1 = core held in reset).
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port res_data, output, PER_W, averaged period in clk cycles.
REQ-013 SHALL have port res_valid, output, 1, result qualifier.
REQ-014 SHALL have port timeout_err, output, 1, sticky no-edge error flag.

Function
REQ-015 SHALL implement states IDLE, CORE_RST, SETTLE, MEASURE, DONE.
REQ-016 IDLE: core_rst=1; (start|cont)=1 -> CORE_RST, latch avg_sel, clear timeout_err, accum, sample count.
REQ-017 CORE_RST: core_rst=1 for exactly RST_CYC cycles, then -> SETTLE with core_rst=0.
REQ-018 Rising edge defined as core_valid=1 with previous-cycle registered core_valid=0.
REQ-019 SETTLE: first rising edge discarded (core setup transient), per_cnt:=1, -> MEASURE.
REQ-020 per_cnt: on edge cycle load 1, else increment, saturating at 2^PER_W-1; edges P cycles apart capture P.
REQ-021 MEASURE: on each edge accum += per_cnt (accum width PER_W+3, no overflow possible), sample count +1.
REQ-022 When sample count reaches 2^avg_sel -> DONE with res_data = accum >> avg_sel (truncate), res_valid=1.
REQ-023 DONE: res_valid and res_data held stable until res_ready=1; handshake completes on the cycle res_valid&res_ready.
REQ-024 After handshake: cont=1 -> SETTLE (accum, count cleared, core not reset); cont=0 -> IDLE.
REQ-025 res_ready=1 in same cycle res_valid first rises SHALL complete the transfer that cycle.
REQ-026 per_cnt saturation in SETTLE or MEASURE SHALL set timeout_err=1, discard partial accum, -> IDLE (core_rst=1).
REQ-027 timeout_err SHALL stay set until the next IDLE->CORE_RST transition.
REQ-028 start while busy=1 SHALL be ignored; cont falling mid-measurement SHALL finish current result then go IDLE.
REQ-029 Edges arriving in DONE SHALL be ignored and not counted.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, core_rst=1, busy=0, res_valid=0, res_data=0, timeout_err=0, per_cnt=0, accum=0, edge register=0.
REQ-031 Reset asserted mid-measurement SHALL drop any pending result without a res_valid pulse.

Structure
REQ-032 State enum, RST_CYC default, and PER_W default SHALL live in shared package tmp_pkg.
REQ-033 Edge detector and saturating period counter SHALL form one sub-module tmp_period_ctr (outputs edge, per_cnt, sat).

Verification
REQ-034 avg_sel=0, edges every 100 cycles, start pulse -> core_rst high 4 cycles, first edge discarded, res_data=100, res_valid until res_ready.
REQ-035 avg_sel=2, edge periods 98,100,102,104 -> res_data=101.
REQ-036 No edges after CORE_RST -> timeout_err=1 after 4095 cycles in SETTLE, busy=0, core_rst=1; next start clears it.
REQ-037 cont=1, res_ready held low 20 cycles -> res_data stable, no edges counted, then SETTLE and second result delivered.
REQ-038 Reset asserted in MEASURE after 2 of 4 samples -> immediate IDLE, no res_valid; restart yields correct 4-sample average.
REQ-039 start pulsed during MEASURE -> no restart, result count and value unchanged.
